// File: rtl/serial_sub8.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first,
// using one full-adder cell with inverted b and carry-in 1.
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Handshake: start is accepted on any edge where the block is in IDLE or
    // DONE; busy is high for the WIDTH cycles of RUN, then done pulses for
    // exactly one cycle with results valid. start during RUN is dropped.

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               s;
    logic               c_next;
    logic               nb;
    logic [WIDTH-1:0]   final_diff;

    assign nb         = ~sb_q[0];
    assign s          = sa_q[0] ^ nb ^ c_q;
    assign c_next     = (sa_q[0] & nb) | (sa_q[0] & c_q) | (nb & c_q);
    assign final_diff = {s, r_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = '0;
                    c_d     = 1'b1;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = final_diff;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    diff_d   = final_diff;
                    // Final carry-out of a + ~b + 1 is the inverse of the unsigned borrow.
                    borrow_d = ~c_next;
                    zero_d   = (final_diff == '0);
                    ovf_d    = (a_msb_q != b_msb_q) && (s != a_msb_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: doc/serial_sub8.md
# serial_sub8

Bit-serial two's-complement subtractor that computes `a - b` one bit per clock, LSB first, using a single full-adder cell with an inverted B input and a carry-in of 1. It sits alongside the 8-bit ripple adder in the arithmetic datapath as its area-minimal inverse: the adder is one-shot combinational, this block is multi-cycle. Operands are taken with a start/busy/done handshake. The difference and status flags are registered and held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse, high in DONE.
- `diff`  out  WIDTH  registered `a - b` modulo 2^WIDTH.
- `borrow`  out  1  unsigned borrow: 1 when `a < b` (unsigned).
- `ovf`  out  1  signed overflow of `a - b`.
- `zero`  out  1  high when `diff == 0`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: processes WIDTH bits.
  - DONE: one cycle long.
- IDLE or DONE with `start = 1`:
  - Load shift registers `sa <= a`, `sb <= b`.
  - Set bit counter to 0 and carry `c <= 1`.
  - Go to RUN.
- DONE with `start = 0`: go to IDLE.
- RUN, each cycle:
  - Compute `s = sa[0] ^ ~sb[0] ^ c`.
  - Compute `c_next = maj(sa[0], ~sb[0], c)`.
  - Shift `s` into the MSB of the internal result register `r`.
  - Shift `sa` and `sb` right by one.
  - Increment the counter.
- RUN, on the cycle that processes bit WIDTH-1 (counter == WIDTH-1):
  - Go to DONE.
  - Load `diff <= {s, r[WIDTH-1:1]}` (the final shifted value).
  - Load `borrow <= ~c_next`.
  - Load `zero <=` (final diff == 0).
  - Load `ovf <= (a_msb != b_msb) && (diff_msb != a_msb)`. The operand MSBs are held in capture registers loaded at start.
- `start` in RUN is ignored: no restart and no queueing.
- `a` and `b` are don't-care except on the accepting edge.
- `diff`, `borrow`, `ovf` and `zero` change only on entry to DONE or on reset. During RUN they hold the previous result.

## Timing
- Reset (`rst = 1` at an edge) gives:
  - state IDLE;
  - `busy = 0`, `done = 0`, `diff = 0`, `borrow = 0`, `ovf = 0`, `zero = 0`;
  - internal shift registers, counter and carry cleared.
- Reset has priority over `start` and aborts an in-flight operation. No done pulse is issued for an aborted operation.
- Cycle numbering, with `start` sampled at edge E0:
  - `busy = 1` from after E0 through E_WIDTH.
  - After edge E_WIDTH: `busy = 0`, `done = 1`, results valid.
  - After E_(WIDTH+1): `done = 0`, unless `start` was high at E_WIDTH.
- Latency is WIDTH clock cycles from the accepting edge to `done`; WIDTH+1 cycles per operation.
- Back-to-back: `start` held high in DONE is accepted at that edge.
  - `busy` rises and `done` falls on the same edge.
  - Throughput is one result per WIDTH+1 cycles.
- `done` is never high for two consecutive cycles.
- `busy` and `done` are never high simultaneously.

## Test plan
- Basic subtract: reset, then `a = 0x05`, `b = 0x03`, pulse `start`. Required: `diff = 0x02`, `borrow = 0`, `ovf = 0`, `zero = 0`; `done` arrives exactly 8 cycles after the start edge; `busy` is high for exactly 8 cycles.
- Unsigned wrap and signed overflow (operations run sequentially, each checked after its `done`):
  - `a = 0x03`, `b = 0x05` gives `diff = 0xFE`, `borrow = 1`, `ovf = 0`.
  - `a = 0x80`, `b = 0x01` gives `diff = 0x7F`, `borrow = 0`, `ovf = 1`.
  - `a = 0x7F`, `b = 0xFF` gives `diff = 0x80`, `borrow = 1`, `ovf = 1`.
- Zero and hold:
  - `a = b = 0x2A` gives `diff = 0x00`, `zero = 1`, `borrow = 0`.
  - Then change `a` and `b` with no start for 20 cycles. All outputs must remain unchanged.
- Ignore while busy:
  - Start `0x10 - 0x01`.
  - At cycle 3 pulse `start` with `a = 0xFF`, `b = 0x00`.
  - Required: only one `done`, with `diff = 0x0F`; no second operation follows.
- Reset mid-operation:
  - Start `0x50 - 0x20`.
  - Assert `rst` at cycle 4.
  - Required: all outputs 0 on the next cycle and no `done` pulse.
  - A following `0x09 - 0x04` completes normally with `diff = 0x05`.
- Back-to-back plus random:
  - Hold `start = 1` continuously. Results appear every 9 cycles; each result corresponds to the operands present on its accepting edge.
  - Then 1000 random operand pairs are checked against a reference model of `(a - b) mod 256` and all flags.
